// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU datapath blocks.
//   EW_DEF / MW_DEF : default exponent / mantissa field widths
//   state_t         : sequencing states of the multi-cycle divider
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EW_DEF = 8;
    localparam int MW_DEF = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_pack.sv
// -----------------------------------------------------------------------------
// fpu_pack
// Concatenates a sign/exponent/mantissa field set into one packed word.
// Ports:
//   i_s    : sign field
//   i_e    : exponent field (EW bits)
//   i_m    : mantissa field (MW bits)
//   o_word : {sign, exponent, mantissa}, 1+EW+MW bits
// -----------------------------------------------------------------------------
module fpu_pack #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic          i_s,
    input  logic [EW-1:0] i_e,
    input  logic [MW-1:0] i_m,
    output logic [EW+MW:0] o_word
);

    assign o_word = {i_s, i_e, i_m};

endmodule

// File: rtl/fpu_seq_div.sv
// -----------------------------------------------------------------------------
// fpu_seq_div
// Radix-2 restoring divider, one quotient bit per clock. Divides the packed
// dividend word {s,e,m} by the packed divisor word {s0,e0,m0} as unsigned
// integers.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a division (only looked at in IDLE)
//   s,e,m / s0,e0,m0  : dividend / divisor field sets
//   op, op0           : packed operands captured at the accepted start
//   quo, rem          : quotient / remainder, valid with done
//   busy              : iteration in progress
//   done              : one-cycle result strobe
//   dz                : divisor was zero (held until the next accepted start)
//   dbg_state         : current FSM state, for observation only
// Handshake: a start seen in IDLE is accepted on that edge; further starts are
// ignored until the FSM is back in IDLE, i.e. the cycle after done.
// -----------------------------------------------------------------------------
module fpu_seq_div
    import fpu_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int MW = MW_DEF,
    parameter int W  = 1 + EW + MW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s,
    input  logic          s0,
    input  logic [EW-1:0] e,
    input  logic [EW-1:0] e0,
    input  logic [MW-1:0] m,
    input  logic [MW-1:0] m0,
    output logic [W-1:0]  op,
    output logic [W-1:0]  op0,
    output logic [W-1:0]  quo,
    output logic [W-1:0]  rem,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(W + 1);

    state_t        r_state;
    logic [W-1:0]  r_prem;
    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  w_op;
    logic [W-1:0]  w_op0;
    logic [W-1:0]  w_shifted;
    logic [W:0]    w_trial;
    logic          w_qbit;
    logic [W-1:0]  w_prem_nxt;
    logic [W-1:0]  w_shreg_nxt;

    fpu_pack #(.EW(EW), .MW(MW)) u_pack_a (
        .i_s    (s),
        .i_e    (e),
        .i_m    (m),
        .o_word (w_op)
    );

    fpu_pack #(.EW(EW), .MW(MW)) u_pack_b (
        .i_s    (s0),
        .i_e    (e0),
        .i_m    (m0),
        .o_word (w_op0)
    );

    // The partial remainder is always below the divisor, and before each shift
    // it is also below 2^(W-1), so dropping its MSB on the shift loses nothing.
    assign w_shifted   = {r_prem[W-2:0], r_shreg[W-1]};
    assign w_trial     = {1'b0, w_shifted} - {1'b0, op0};
    assign w_qbit      = ~w_trial[W];
    assign w_prem_nxt  = w_qbit ? w_trial[W-1:0] : w_shifted;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_shreg_nxt = {r_shreg[W-2:0], w_qbit};

    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prem  <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            op      <= '0;
            op0     <= '0;
            quo     <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        op  <= w_op;
                        op0 <= w_op0;
                        dz  <= 1'b0;
                        if (w_op0 == '0) begin
                            // No iteration: report straight away from FIN.
                            dz      <= 1'b1;
                            quo     <= '1;
                            rem     <= w_op;
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_prem  <= '0;
                            r_shreg <= w_op;
                            r_cnt   <= CW'(W);
                            busy    <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_prem  <= w_prem_nxt;
                    r_shreg <= w_shreg_nxt;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // Results are registered on entry so they are valid
                        // throughout the FIN cycle alongside done.
                        quo     <= w_shreg_nxt;
                        rem     <= w_prem_nxt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
